// File: rtl/bank_arbiter_2m.sv
// rtl/bank_arbiter_2m.sv - two-master round-robin arbiter in front of one single-port RAM bank
// Reads return through a per-master registered response slot; writes have no response.
module bank_arbiter_2m #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [1:0]                 inflight_q, inflight_d;
  logic [1:0]                 rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                       prio_q, prio_d;

  logic [1:0] req_valid, req_we, rsp_ready, elig, grant;

  assign req_valid = {m1_req_valid, m0_req_valid};
  assign req_we    = {m1_req_we, m0_req_we};
  assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};

  // A read may only go out when its slot will be free by the time the data lands.
  always_comb begin
    elig  = 2'b00;
    grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] &
                (req_we[i] | (~inflight_q[i] & (~rsp_valid_q[i] | rsp_ready[i])));
    end
    if (rst_n) begin
      if (elig == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else               grant = elig;
    end
  end

  always_comb begin
    ram_en    = |grant;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant[0]) begin
      ram_we    = m0_req_we;
      ram_addr  = m0_req_addr;
      ram_wdata = m0_req_wdata;
    end else if (grant[1]) begin
      ram_we    = m1_req_we;
      ram_addr  = m1_req_addr;
      ram_wdata = m1_req_wdata;
    end
  end

  always_comb begin
    inflight_d  = 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    prio_d      = prio_q;
    for (int i = 0; i < 2; i++) begin
      if (rsp_valid_q[i] & rsp_ready[i]) rsp_valid_d[i] = 1'b0;
      // capture overrides a same-edge accept
      if (inflight_q[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = ram_rdata;
      end
      if (grant[i] & ~req_we[i]) inflight_d[i] = 1'b1;
    end
    if (grant != 2'b00) prio_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q  <= 2'b00;
      rsp_valid_q <= 2'b00;
      prio_q      <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      prio_q      <= prio_d;
    end
    rsp_data_q <= rsp_data_d;
  end

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign m0_rsp_valid = rsp_valid_q[0] & rst_n;
  assign m1_rsp_valid = rsp_valid_q[1] & rst_n;
  assign m0_rsp_rdata = rsp_data_q[0];
  assign m1_rsp_rdata = rsp_data_q[1];

endmodule

// File: tb/tb_bank_arbiter_2m.sv
// tb/tb_bank_arbiter_2m.sv - directed bench for bank_arbiter_2m with a transaction-level model
// The model tracks each master's outstanding read as (data, cycle it becomes visible).
module tb_bank_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready;
  logic [9:0]  m0_req_addr;
  logic [63:0] m0_req_wdata, m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready;
  logic [9:0]  m1_req_addr;
  logic [63:0] m1_req_wdata, m1_rsp_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bank_arbiter_2m #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // single-port bank, one-cycle read latency
  logic [63:0] mem [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] shadow [1024];
  int          mcyc = 0;
  int          first = 0;
  bit          has [2];
  logic [63:0] edata [2];
  int          avail [2];
  bit          v [2], we [2], rr [2], vis [2], inf [2], el [2];
  logic [9:0]  ad [2];
  logic [63:0] wd [2];
  int          g;

  always @(negedge clk) begin
    mcyc++;
    v[0] = m0_req_valid;  v[1] = m1_req_valid;
    we[0] = m0_req_we;    we[1] = m1_req_we;
    rr[0] = m0_rsp_ready; rr[1] = m1_rsp_ready;
    ad[0] = m0_req_addr;  ad[1] = m1_req_addr;
    wd[0] = m0_req_wdata; wd[1] = m1_req_wdata;
    if (!rst_n) begin
      check("m_rst_en", ram_en, 0);
      check("m_rst_rdy0", m0_req_ready, 0);
      check("m_rst_rdy1", m1_req_ready, 0);
      check("m_rst_rsp0", m0_rsp_valid, 0);
      check("m_rst_rsp1", m1_rsp_valid, 0);
      has[0] = 0; has[1] = 0; first = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        vis[i] = has[i] && avail[i] <= mcyc;
        inf[i] = has[i] && avail[i] > mcyc;
        el[i]  = v[i] && (we[i] || (!inf[i] && (!vis[i] || rr[i])));
      end
      if (el[0] && el[1]) g = first;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      else                g = -1;
      check("m_rdy0", m0_req_ready, g == 0);
      check("m_rdy1", m1_req_ready, g == 1);
      check("m_en", ram_en, g >= 0);
      check("m_rsp0", m0_rsp_valid, vis[0]);
      check("m_rsp1", m1_rsp_valid, vis[1]);
      if (vis[0]) check("m_rdata0", m0_rsp_rdata, edata[0]);
      if (vis[1]) check("m_rdata1", m1_rsp_rdata, edata[1]);
      if (g >= 0) begin
        check("m_we", ram_we, we[g]);
        check("m_addr", ram_addr, ad[g]);
        if (we[g]) check("m_wdata", ram_wdata, wd[g]);
      end
      for (int i = 0; i < 2; i++) if (vis[i] && rr[i]) has[i] = 0;
      if (g >= 0) begin
        if (we[g]) shadow[ad[g]] = wd[g];
        else begin
          has[g] = 1; edata[g] = shadow[ad[g]]; avail[g] = mcyc + 2;
        end
        first = 1 - g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic mid(); @(negedge clk); #1; endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, a1;
    int n0i, n1i, n0r, n1r;
    rst_n = 1'b0;
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 10'd1; m0_req_wdata = 64'h11; m0_rsp_ready = 0;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'd2; m1_req_wdata = 64'h22; m1_rsp_ready = 0;

    // reset held while both masters request
    repeat (3) begin
      mid();
      check("rst_en", ram_en, 0);
      check("rst_rdy0", m0_req_ready, 0);
      check("rst_rdy1", m1_req_ready, 0);
      nxt();
    end
    rst_n = 1'b1;
    mid(); check("first_grant_m0", m0_req_ready, 1); check("first_grant_not_m1", m1_req_ready, 0);
    nxt(); m0_req_valid = 0;
    mid(); check("then_m1", m1_req_ready, 1);
    nxt(); m1_req_valid = 0;

    // write then read-back on m0
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 10'd5; m0_req_wdata = 64'hA5;
    mid(); check("wr5_rdy", m0_req_ready, 1);
    nxt(); m0_req_we = 0;
    mid(); check("rd5_rdy", m0_req_ready, 1);
    nxt(); m0_req_valid = 0; m0_rsp_ready = 1;
    mid(); check("rd5_not_yet", m0_rsp_valid, 0);
    nxt();
    mid(); check("rd5_valid", m0_rsp_valid, 1); check("rd5_data", m0_rsp_rdata, 64'hA5);
    nxt();

    // continuous writes: grants alternate, m1 first because m0 was served last
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 10'd16; m0_req_wdata = 64'h1010;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'd32; m1_req_wdata = 64'h1020;
    n0i = 0; n1i = 0;
    for (int k = 0; k < 8; k++) begin
      mid();
      check("wr_bank_busy", ram_en, 1);
      check("wr_alt_m1", m1_req_ready, (k % 2) == 0);
      check("wr_alt_m0", m0_req_ready, (k % 2) == 1);
      a0 = m0_req_ready; a1 = m1_req_ready;
      nxt();
      if (a0) begin
        n0i++;
        if (n0i == 4) m0_req_valid = 0;
        else begin m0_req_addr = m0_req_addr + 10'd1; m0_req_wdata = 64'h1000 + 64'(m0_req_addr); end
      end
      if (a1) begin
        n1i++;
        if (n1i == 4) m1_req_valid = 0;
        else begin m1_req_addr = m1_req_addr + 10'd1; m1_req_wdata = 64'h1000 + 64'(m1_req_addr); end
      end
    end

    // response backpressure stalls the next read
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'd3; m1_req_wdata = 64'h33;
    mid(); check("wr3_rdy", m1_req_ready, 1);
    nxt(); m1_req_valid = 0;
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 10'd3; m0_rsp_ready = 0;
    mid(); check("rd3_rdy", m0_req_ready, 1);
    nxt(); m0_req_addr = 10'd5;
    mid(); check("stall_inflight", m0_req_ready, 0); check("rd3_pending", m0_rsp_valid, 0);
    nxt();
    for (int j = 0; j < 4; j++) begin
      mid();
      check("stall_slot_full", m0_req_ready, 0);
      check("hold_valid", m0_rsp_valid, 1);
      check("hold_data", m0_rsp_rdata, 64'h33);
      nxt();
    end
    m0_rsp_ready = 1;
    mid(); check("unstall_rdy", m0_req_ready, 1); check("accept_valid", m0_rsp_valid, 1);
    nxt(); m0_req_valid = 0;
    mid(); check("slot_popped", m0_rsp_valid, 0);
    nxt();
    mid(); check("rd5b_valid", m0_rsp_valid, 1); check("rd5b_data", m0_rsp_rdata, 64'hA5);
    nxt();

    // interleaved continuous reads keep the bank busy every cycle
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 10'd16; m0_rsp_ready = 1;
    m1_req_valid = 1; m1_req_we = 0; m1_req_addr = 10'd32; m1_rsp_ready = 1;
    n0i = 0; n1i = 0; n0r = 0; n1r = 0;
    for (int k = 0; k < 14; k++) begin
      mid();
      if (k < 8) check("rd_bank_busy", ram_en, 1);
      if (m0_rsp_valid) begin check("rd0_data", m0_rsp_rdata, 64'h1010 + 64'(n0r)); n0r++; end
      if (m1_rsp_valid) begin check("rd1_data", m1_rsp_rdata, 64'h1020 + 64'(n1r)); n1r++; end
      a0 = m0_req_ready; a1 = m1_req_ready;
      nxt();
      if (a0) begin n0i++; if (n0i == 4) m0_req_valid = 0; else m0_req_addr = m0_req_addr + 10'd1; end
      if (a1) begin n1i++; if (n1i == 4) m1_req_valid = 0; else m1_req_addr = m1_req_addr + 10'd1; end
    end
    check("rd0_count", 64'(n0r), 4);
    check("rd1_count", 64'(n1r), 4);

    // reset while a read is in flight
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 10'd5;
    mid(); check("rd_pre_rst", m0_req_ready, 1);
    nxt(); m0_req_valid = 0; rst_n = 1'b0;
    mid(); check("rst_no_rsp", m0_rsp_valid, 0);
    nxt(); rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mid(); check("dropped_rsp", m0_rsp_valid, 0);
      nxt();
    end
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 10'd7; m0_req_wdata = 64'h77;
    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 10'd8; m1_req_wdata = 64'h88;
    mid(); check("post_rst_m0", m0_req_ready, 1); check("post_rst_not_m1", m1_req_ready, 0);
    nxt(); m0_req_valid = 0;
    mid(); check("post_rst_m1", m1_req_ready, 1);
    nxt(); m1_req_valid = 0;
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
